// File: rtl/jtframe_sdram_arb.sv
// ---------------------------------------------------------------------------
// jtframe_sdram_arb
// Shares a single SDRAM command engine between four game bank requesters
// (ba0..ba3) and the ROM download / programming port (prog_*). Exactly one
// transaction is in flight at a time. The engine's ack/dst/dok/rdy strobes
// are routed back to the requester that owns the transaction and to nobody
// else.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   downloading       1: only the prog port is served, banks are ignored
//   ba_rd, ba_wr      per-bank level requests, held until ba_ack
//   ba_addr           {ba3,ba2,ba1,ba0} word addresses, AW bits each
//   ba_din, ba_dsn    per-bank write data (16 b) and byte masks (2 b, act-low)
//   ba_ack/dst/dok/rdy per-bank strobes back to the owner
//   prog_*            programming port request, fields and strobes
//   cmd_*             request and fields towards the engine, engine strobes
//   st_dbg            current FSM state (0 idle, 1 issue, 2 wait)
//
// Handshake: cmd_req is a valid that stays high with cmd_we/ba/addr/din/dsn
// stable until the engine answers with cmd_ack; the transfer happens in the
// cycle where cmd_req and cmd_ack are both high. Requester sides work the
// same way: the level request is the valid and the one-cycle ack is the
// ready. Completion is signalled separately by a one-cycle rdy.
// ---------------------------------------------------------------------------
module jtframe_sdram_arb #(
   parameter int AW = 22,
   parameter bit RR = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            downloading,
   // game bank side
   input  logic [3:0]      ba_rd,
   input  logic [3:0]      ba_wr,
   input  logic [4*AW-1:0] ba_addr,
   input  logic [63:0]     ba_din,
   input  logic [7:0]      ba_dsn,
   output logic [3:0]      ba_ack,
   output logic [3:0]      ba_dst,
   output logic [3:0]      ba_dok,
   output logic [3:0]      ba_rdy,
   // programming side
   input  logic            prog_rd,
   input  logic            prog_we,
   input  logic [AW-1:0]   prog_addr,
   input  logic [1:0]      prog_ba,
   input  logic [15:0]     prog_data,
   input  logic [1:0]      prog_mask,
   output logic            prog_ack,
   output logic            prog_dst,
   output logic            prog_dok,
   output logic            prog_rdy,
   // command engine side
   output logic            cmd_req,
   output logic            cmd_we,
   output logic [1:0]      cmd_ba,
   output logic [AW-1:0]   cmd_addr,
   output logic [15:0]     cmd_din,
   output logic [1:0]      cmd_dsn,
   input  logic            cmd_ack,
   input  logic            cmd_dst,
   input  logic            cmd_dok,
   input  logic            cmd_rdy,
   // debug
   output logic [1:0]      st_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state;
   logic        owner_prog;   // 1: prog port owns the current transaction
   logic [1:0]  owner;        // bank index when owner_prog is 0
   logic [1:0]  rr_ptr;       // first bank examined by the next search

   // ------------------------------------------------------------------
   // Bank selection. A bank requests when either rd or wr is high.
   // With RR the search starts at rr_ptr and wraps 3 -> 0; without RR it
   // always starts at bank 0, giving fixed priority ba0 > ba3.
   // ------------------------------------------------------------------
   logic [3:0]    bank_req;
   logic [1:0]    scan_base;
   logic [1:0]    idx;
   logic [1:0]    pick;
   logic          pick_vld;
   logic [AW-1:0] sel_addr;
   logic [15:0]   sel_din;
   logic [1:0]    sel_dsn;

   assign bank_req = ba_rd | ba_wr;

   always_comb begin
      scan_base = RR ? rr_ptr : 2'd0;
      idx       = 2'd0;
      pick      = 2'd0;
      pick_vld  = 1'b0;
      // Walk the offsets from farthest to nearest so the last hit, i.e.
      // the nearest requester to scan_base, is the one that sticks.
      for (int i = 3; i >= 0; i--) begin
         idx = scan_base + 2'(i);
         if (bank_req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
      sel_addr = '0;
      sel_din  = '0;
      sel_dsn  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         if (pick == 2'(i)) begin
            sel_addr = ba_addr[i*AW +: AW];
            sel_din  = ba_din[i*16 +: 16];
            sel_dsn  = ba_dsn[i*2 +: 2];
         end
      end
   end

   // ------------------------------------------------------------------
   // Transaction FSM. All cmd_* outputs are registered; they are loaded
   // when leaving IDLE and held untouched until the next grant.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_req    <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_ba     <= 2'd0;
         cmd_addr   <= '0;
         cmd_din    <= 16'd0;
         cmd_dsn    <= 2'b11;
         owner_prog <= 1'b0;
         owner      <= 2'd0;
         rr_ptr     <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (downloading) begin
                  if (prog_rd | prog_we) begin
                     owner_prog <= 1'b1;
                     cmd_we     <= prog_we;
                     cmd_ba     <= prog_ba;
                     cmd_addr   <= prog_addr;
                     cmd_din    <= prog_data;
                     cmd_dsn    <= prog_mask;
                     cmd_req    <= 1'b1;
                     state      <= ISSUE;
                  end
               end else if (pick_vld) begin
                  owner_prog <= 1'b0;
                  owner      <= pick;
                  // a bank raising rd and wr together is treated as a write
                  cmd_we     <= ba_wr[pick];
                  cmd_ba     <= pick;
                  cmd_addr   <= sel_addr;
                  cmd_din    <= sel_din;
                  cmd_dsn    <= sel_dsn;
                  cmd_req    <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_ack) begin
                  cmd_req <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cmd_rdy) begin
                  // only bank grants advance the round-robin pointer
                  if (!owner_prog) rr_ptr <= owner + 2'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Strobe routing. ack is only meaningful while issuing, dst/dok/rdy
   // only while waiting; everything is masked to the current owner.
   // ------------------------------------------------------------------
   logic [3:0] own_hot;
   logic       in_issue;
   logic       in_wait;

   assign own_hot  = owner_prog ? 4'b0000 : (4'b0001 << owner);
   assign in_issue = (state == ISSUE);
   assign in_wait  = (state == WAIT);

   assign ba_ack   = {4{in_issue & cmd_ack}} & own_hot;
   assign ba_dst   = {4{in_wait  & cmd_dst}} & own_hot;
   assign ba_dok   = {4{in_wait  & cmd_dok}} & own_hot;
   assign ba_rdy   = {4{in_wait  & cmd_rdy}} & own_hot;

   assign prog_ack = in_issue & cmd_ack & owner_prog;
   assign prog_dst = in_wait  & cmd_dst & owner_prog;
   assign prog_dok = in_wait  & cmd_dok & owner_prog;
   assign prog_rdy = in_wait  & cmd_rdy & owner_prog;

   assign st_dbg   = state;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;
  localparam int AW = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (round robin) ----------------
  logic            downloading;
  logic [3:0]      ba_rd, ba_wr;
  logic [4*AW-1:0] ba_addr;
  logic [63:0]     ba_din;
  logic [7:0]      ba_dsn;
  logic [3:0]      ba_ack, ba_dst, ba_dok, ba_rdy;
  logic            prog_rd, prog_we;
  logic [AW-1:0]   prog_addr;
  logic [1:0]      prog_ba;
  logic [15:0]     prog_data;
  logic [1:0]      prog_mask;
  logic            prog_ack, prog_dst, prog_dok, prog_rdy;
  logic            cmd_req, cmd_we;
  logic [1:0]      cmd_ba;
  logic [AW-1:0]   cmd_addr;
  logic [15:0]     cmd_din;
  logic [1:0]      cmd_dsn;
  logic            cmd_ack, cmd_dst, cmd_dok, cmd_rdy;
  logic [1:0]      st_dbg;

  jtframe_sdram_arb #(.AW(AW), .RR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_addr(ba_addr), .ba_din(ba_din), .ba_dsn(ba_dsn),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .prog_rd(prog_rd), .prog_we(prog_we), .prog_addr(prog_addr), .prog_ba(prog_ba),
    .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok), .prog_rdy(prog_rdy),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .cmd_din(cmd_din), .cmd_dsn(cmd_dsn),
    .cmd_ack(cmd_ack), .cmd_dst(cmd_dst), .cmd_dok(cmd_dok), .cmd_rdy(cmd_rdy),
    .st_dbg(st_dbg)
  );

  // ---------------- second DUT (fixed priority) ----------------
  logic [3:0]      f_ba_rd;
  logic [4*AW-1:0] f_ba_addr;
  logic [3:0]      f_ba_ack, f_ba_dst, f_ba_dok, f_ba_rdy;
  logic            f_prog_ack, f_prog_dst, f_prog_dok, f_prog_rdy;
  logic            f_cmd_req, f_cmd_we;
  logic [1:0]      f_cmd_ba;
  logic [AW-1:0]   f_cmd_addr;
  logic [15:0]     f_cmd_din;
  logic [1:0]      f_cmd_dsn;
  logic            f_cmd_ack, f_cmd_rdy;
  logic [1:0]      f_st_dbg;

  jtframe_sdram_arb #(.AW(AW), .RR(1'b0)) u_fix (
    .clk(clk), .rst(rst), .downloading(1'b0),
    .ba_rd(f_ba_rd), .ba_wr(4'b0000), .ba_addr(f_ba_addr), .ba_din(64'd0), .ba_dsn(8'hff),
    .ba_ack(f_ba_ack), .ba_dst(f_ba_dst), .ba_dok(f_ba_dok), .ba_rdy(f_ba_rdy),
    .prog_rd(1'b0), .prog_we(1'b0), .prog_addr('0), .prog_ba(2'd0),
    .prog_data(16'd0), .prog_mask(2'b11),
    .prog_ack(f_prog_ack), .prog_dst(f_prog_dst), .prog_dok(f_prog_dok), .prog_rdy(f_prog_rdy),
    .cmd_req(f_cmd_req), .cmd_we(f_cmd_we), .cmd_ba(f_cmd_ba), .cmd_addr(f_cmd_addr),
    .cmd_din(f_cmd_din), .cmd_dsn(f_cmd_dsn),
    .cmd_ack(f_cmd_ack), .cmd_dst(1'b0), .cmd_dok(1'b0), .cmd_rdy(f_cmd_rdy),
    .st_dbg(f_st_dbg)
  );

  // ---------------- reference model ----------------
  // Requesters: what each port currently asks for. Owner 0..3 = bank, 4 = prog.
  logic          m_rd[4], m_wr[4];
  logic [AW-1:0] m_addr[4];
  logic [15:0]   m_din[4];
  logic [1:0]    m_dsn[4];
  logic          m_dl, m_prd, m_pwe;
  logic [AW-1:0] m_paddr;
  logic [1:0]    m_pba;
  logic [15:0]   m_pdata;
  logic [1:0]    m_pmask;
  int            m_ptr;      // bank that the next search starts from
  logic [7:0]    exp_q[$];   // expected owners, in grant order
  int            cur_own;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int b = 0; b < 4; b++) begin
      ba_rd[b]            = m_rd[b];
      ba_wr[b]            = m_wr[b];
      ba_addr[b*AW +: AW] = m_addr[b];
      ba_din[b*16 +: 16]  = m_din[b];
      ba_dsn[b*2 +: 2]    = m_dsn[b];
    end
    downloading = m_dl;
    prog_rd     = m_prd;
    prog_we     = m_pwe;
    prog_addr   = m_paddr;
    prog_ba     = m_pba;
    prog_data   = m_pdata;
    prog_mask   = m_pmask;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 4; b++) begin
      m_rd[b] = 1'b0; m_wr[b] = 1'b0; m_addr[b] = '0; m_din[b] = 16'd0; m_dsn[b] = 2'b11;
    end
    m_dl = 1'b0; m_prd = 1'b0; m_pwe = 1'b0;
    m_paddr = '0; m_pba = 2'd0; m_pdata = 16'd0; m_pmask = 2'b11;
  endtask

  task automatic new_bank(input int b);
    int k;
    k = $urandom_range(0, 2);
    m_rd[b]   = (k != 1);
    m_wr[b]   = (k != 0);
    m_addr[b] = AW'($urandom);
    m_din[b]  = 16'($urandom);
    m_dsn[b]  = 2'($urandom);
  endtask

  task automatic new_prog();
    m_pwe   = 1'($urandom_range(0, 1));
    m_prd   = !m_pwe;
    m_paddr = AW'($urandom);
    m_pba   = 2'($urandom);
    m_pdata = 16'($urandom);
    m_pmask = 2'($urandom);
  endtask

  // Who the arbiter must pick next given the current requests; -1 = nobody.
  function automatic int model_pick();
    int b;
    if (m_dl) return (m_prd || m_pwe) ? 4 : -1;
    for (int i = 0; i < 4; i++) begin
      b = (m_ptr + i) % 4;
      if (m_rd[b] || m_wr[b]) return b;
    end
    return -1;
  endfunction

  // Expected strobe bundle {ack,dst,dok,rdy}, each {prog,ba[3:0]}.
  function automatic logic [19:0] exp_b(input int own, input int which);
    logic [4:0] h;
    h = (own == 4) ? 5'b10000 : 5'(1 << own);
    return {15'd0, h} << (5 * (3 - which));
  endfunction

  function automatic logic [19:0] obs_b();
    return {prog_ack, ba_ack, prog_dst, ba_dst, prog_dok, ba_dok, prog_rdy, ba_rdy};
  endfunction

  // Engine driver: wait for the request, check fields, ack it.
  task automatic serve_issue(input string tag, input bit drop);
    int own;
    bit ok;
    logic e_we;
    logic [1:0] e_ba, e_dsn;
    logic [AW-1:0] e_addr;
    logic [15:0] e_din;
    own = int'(exp_q.pop_front());
    cur_own = own;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_req"}, 64'(ok), 64'd1);
    if (!ok) return;
    if (own == 4) begin
      e_we = m_pwe; e_ba = m_pba; e_addr = m_paddr; e_din = m_pdata; e_dsn = m_pmask;
    end else begin
      e_we = m_wr[own]; e_ba = 2'(own); e_addr = m_addr[own]; e_din = m_din[own]; e_dsn = m_dsn[own];
    end
    chk({tag, "_fields"}, 64'({cmd_we, cmd_ba, cmd_addr, cmd_din, cmd_dsn}),
        64'({e_we, e_ba, e_addr, e_din, e_dsn}));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk({tag, "_hold"}, 64'({cmd_req, cmd_addr, cmd_ba}), 64'({1'b1, e_addr, e_ba}));
    cmd_ack = 1'b1;
    #1;
    chk({tag, "_ack"}, 64'(obs_b()), 64'(exp_b(own, 0)));
    @(negedge clk);
    cmd_ack = 1'b0;
    #1;
    chk({tag, "_req_drop"}, 64'({cmd_req, obs_b()}), 64'd0);
    if (drop) begin
      if (own == 4) begin m_prd = 1'b0; m_pwe = 1'b0; end
      else begin m_rd[own] = 1'b0; m_wr[own] = 1'b0; end
      apply();
    end
  endtask

  // Engine driver: data strobes then completion.
  task automatic serve_finish(input string tag, input int n_dok);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    cmd_dst = 1'b1;
    #1;
    chk({tag, "_dst"}, 64'(obs_b()), 64'(exp_b(cur_own, 1)));
    @(negedge clk);
    cmd_dst = 1'b0;
    for (int i = 0; i < n_dok; i++) begin
      cmd_dok = 1'b1;
      #1;
      chk({tag, "_dok"}, 64'(obs_b()), 64'(exp_b(cur_own, 2)));
      @(negedge clk);
      cmd_dok = 1'b0;
    end
    cmd_rdy = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(obs_b()), 64'(exp_b(cur_own, 3)));
    @(posedge clk);
    if (cur_own < 4) m_ptr = (cur_own + 1) % 4;
    @(negedge clk);
    cmd_rdy = 1'b0;
    #1;
    chk({tag, "_quiet"}, 64'(obs_b()), 64'd0);
  endtask

  task automatic txn(input string tag, input int n_dok);
    exp_q.push_back(8'(model_pick()));
    serve_issue(tag, 1'b1);
    serve_finish(tag, n_dok);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    rst = 1'b1;
    cmd_ack = 1'b0; cmd_dst = 1'b0; cmd_dok = 1'b0; cmd_rdy = 1'b0;
    f_ba_rd = 4'b0000; f_ba_addr = '0; f_cmd_ack = 1'b0; f_cmd_rdy = 1'b0;
    m_ptr = 0;
    clear_model();
    apply();
    repeat (3) @(negedge clk);

    // reset state
    chk("reset_cmd", 64'({cmd_req, cmd_we, cmd_ba, cmd_addr, cmd_din, cmd_dsn}), 64'({1'b0, 1'b0, 2'd0, 22'd0, 16'd0, 2'b11}));
    chk("reset_strobes", 64'(obs_b()), 64'd0);
    chk("reset_state", 64'(st_dbg), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single read from bank 0, one-clock request latency
    m_rd[0] = 1'b1; m_addr[0] = AW'(22'h1234);
    apply();
    #1;
    chk("t1_no_req_yet", 64'(cmd_req), 64'd0);
    @(negedge clk);
    chk("t1_latency", 64'({cmd_req, cmd_ba, cmd_addr}), 64'({1'b1, 2'd0, 22'h1234}));
    txn("t1", 1);

    // 2: all banks held, round robin from reset -> 0,1,2,3,0
    rst = 1'b1;
    @(negedge clk);
    m_ptr = 0;
    for (int b = 0; b < 4; b++) begin m_rd[b] = 1'b1; m_addr[b] = AW'(32'h100 * (b + 1)); end
    apply();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", 64'(model_pick()), 64'(k % 4));
      exp_q.push_back(8'(model_pick()));
      serve_issue("t2", 1'b0);
      if (k == 4) begin clear_model(); apply(); end
      serve_finish("t2", 1);
    end

    // 3: download serves only prog; dropping it mid-transfer then bank 0
    m_dl = 1'b1; m_pwe = 1'b1; m_pba = 2'd2; m_paddr = AW'(22'h2aaaa); m_pdata = 16'h5a5a; m_pmask = 2'b01;
    m_rd[0] = 1'b1; m_addr[0] = AW'(22'h0777);
    apply();
    exp_q.push_back(8'(model_pick()));
    serve_issue("t3_prog", 1'b1);
    m_dl = 1'b0;
    apply();
    serve_finish("t3_prog", 2);
    txn("t3_bank0", 1);

    // 4: rd+wr together on bank 1 is a write with its own mask/data
    m_rd[1] = 1'b1; m_wr[1] = 1'b1; m_dsn[1] = 2'b10; m_din[1] = 16'hbeef; m_addr[1] = AW'(22'h3c3c3);
    apply();
    txn("t4", 1);

    // 5: data strobes while bank 3 owns the engine
    m_rd[3] = 1'b1; m_addr[3] = AW'(22'h00333);
    apply();
    txn("t5", 3);

    // request raised and withdrawn while busy is never served
    m_rd[0] = 1'b1;
    apply();
    exp_q.push_back(8'(model_pick()));
    serve_issue("drop", 1'b1);
    m_rd[2] = 1'b1; apply();
    @(negedge clk);
    m_rd[2] = 1'b0; apply();
    serve_finish("drop", 1);
    ok = 1'b0;
    repeat (4) begin @(negedge clk); if (cmd_req) ok = 1'b1; end
    chk("drop_not_served", 64'(ok), 64'd0);

    // downloading rises during a bank transfer: prog is next, then the bank
    m_rd[1] = 1'b1; apply();
    exp_q.push_back(8'(model_pick()));
    serve_issue("dlrise_bank", 1'b1);
    m_dl = 1'b1; new_prog(); m_rd[3] = 1'b1; m_addr[3] = AW'(22'h12321);
    apply();
    serve_finish("dlrise_bank", 1);
    chk("dlrise_pick", 64'(model_pick()), 64'd4);
    exp_q.push_back(8'(model_pick()));
    serve_issue("dlrise_prog", 1'b1);
    m_dl = 1'b0; apply();
    serve_finish("dlrise_prog", 1);
    txn("dlrise_after", 1);

    // 6: reset while waiting for the engine
    m_rd[2] = 1'b1; apply();
    exp_q.push_back(8'(model_pick()));
    serve_issue("t6", 1'b1);
    rst = 1'b1; cmd_dok = 1'b1;
    @(negedge clk);
    chk("t6_cmd_req", 64'(cmd_req), 64'd0);
    chk("t6_state", 64'(st_dbg), 64'd0);
    chk("t6_strobes", 64'(obs_b()), 64'd0);
    m_ptr = 0;
    for (int b = 0; b < 4; b++) m_rd[b] = 1'b1;
    apply();
    rst = 1'b0; cmd_dok = 1'b0;
    chk("t6_ptr_pick", 64'(model_pick()), 64'd0);
    exp_q.push_back(8'(model_pick()));
    serve_issue("t6_after", 1'b1);
    clear_model(); apply();
    serve_finish("t6_after", 1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (model_pick() < 0) begin
        if (m_dl) new_prog(); else new_bank($urandom_range(0, 3));
        apply();
      end
      exp_q.push_back(8'(model_pick()));
      serve_issue("rand", 1'b1);
      if ($urandom_range(0, 3) == 0) m_dl = !m_dl;
      for (int b = 0; b < 4; b++)
        if (!(m_rd[b] || m_wr[b]) && $urandom_range(0, 2) == 0) new_bank(b);
      if (!(m_prd || m_pwe) && $urandom_range(0, 1) == 0) new_prog();
      if (n == 39) clear_model();
      apply();
      serve_finish("rand", $urandom_range(1, 4));
    end

    // fixed priority instance: bank 0 wins every time while all request
    for (int b = 0; b < 4; b++) f_ba_addr[b*AW +: AW] = AW'(32'h2000 + b);
    f_ba_rd = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (f_cmd_req) begin ok = 1'b1; break; end
      end
      chk("fix_req", 64'(ok), 64'd1);
      chk("fix_grant", 64'({f_cmd_ba, f_cmd_addr}), 64'({2'd0, 22'h2000}));
      f_cmd_ack = 1'b1;
      #1;
      chk("fix_ack", 64'(f_ba_ack), 64'b0001);
      @(negedge clk);
      f_cmd_ack = 1'b0;
      f_cmd_rdy = 1'b1;
      #1;
      chk("fix_rdy", 64'(f_ba_rdy), 64'b0001);
      @(negedge clk);
      f_cmd_rdy = 1'b0;
    end
    f_ba_rd = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
